base_initsink: RTL

BASE_INITSINK -- requirements
Module: base_initsink

---
 rtl/base_initsink_pkg.sv | 14 +
 rtl/base_vlat_en.sv | 24 ++
 rtl/base_initsink.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/base_initsink_pkg.sv
// Shared types for the init-sink block: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package base_initsink_pkg;

    // INIT must encode as 0 so the reset value of the state cell selects it.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic STATE_RSTV = 1'b0;

endpackage : base_initsink_pkg

// File: rtl/base_vlat_en.sv
// Enabled register cell: q loads d on the rising edge when en is high.
// Latency: 1 cycle from d to q.
// Backpressure: none; the enable is the only hold mechanism.
module base_vlat_en #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] RSTV  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Async active-low clear to RSTV; otherwise load on enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RSTV;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : base_vlat_en

// File: rtl/base_initsink.sv
// Memory init sink: writes INITV to each index of an init stream, then forwards functional writes.
// Latency: 1 cycle from accepted beat to registered write port; one beat per cycle, no bubbles.
// Backpressure: init stream is always ready; functional writes are held off (i_wr_r=0) until init ends.
// Optional feature: define BASE_INITSINK_CHECK_EN to enable expected-index checking and o_err.
module base_initsink
    import base_initsink_pkg::*;
#(
    parameter int               LOG_COUNT = 1,
    parameter int               COUNT     = 2**LOG_COUNT,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] INITV     = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_init_v,
    input  logic [0:LOG_COUNT-1] i_init_d,
    output logic               i_init_r,
    input  logic               i_wr_v,
    input  logic [0:LOG_COUNT-1] i_wr_a,
    input  logic [0:WIDTH-1]   i_wr_d,
    output logic               i_wr_r,
    output logic               o_we,
    output logic [0:LOG_COUNT-1] o_wa,
    output logic [0:WIDTH-1]   o_wd,
    output logic               o_done,
    output logic               o_err
);

    state_t               state_q;
    state_t               state_d;
    logic                 state_q_bit;
    logic                 state_d_bit;

    logic                 init_acc;
    logic                 we_d;
    logic [LOG_COUNT-1:0] wa_d;
    logic [WIDTH-1:0]     wd_d;
    logic                 done_set;

    logic [LOG_COUNT-1:0] wa_q;
    logic [WIDTH-1:0]     wd_q;

    assign state_d_bit = state_d;
    assign state_q     = state_t'(state_q_bit);

    // The init stream is never stalled; in RUN its beats are simply drained.
    assign init_acc = i_init_v & i_init_r;

    // Next-state and write-port selection; the init path owns the port until index 0 is seen.
    always_comb begin
        state_d  = state_q;
        i_init_r = 1'b1;
        i_wr_r   = 1'b0;
        we_d     = 1'b0;
        wa_d     = i_init_d;
        wd_d     = INITV;
        done_set = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_acc) begin
                    we_d = 1'b1;
                    wa_d = i_init_d;
                    wd_d = INITV;
                    if (i_init_d == '0) begin
                        state_d  = ST_RUN;
                        done_set = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                i_wr_r = 1'b1;
                wa_d   = i_wr_a;
                wd_d   = i_wr_d;
                we_d   = i_wr_v;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    base_vlat_en #(.WIDTH(1), .RSTV(STATE_RSTV)) u_state (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (state_d_bit),
        .q     (state_q_bit)
    );

    // Write strobe is reloaded every cycle so it drops after an idle cycle.
    base_vlat_en #(.WIDTH(1), .RSTV(1'b0)) u_we (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (we_d),
        .q     (o_we)
    );

    // Address and data only move on a real write, holding their last value otherwise.
    base_vlat_en #(.WIDTH(LOG_COUNT), .RSTV('0)) u_wa (
        .clk   (clk),
        .reset (reset),
        .en    (we_d),
        .d     (wa_d),
        .q     (wa_q)
    );

    base_vlat_en #(.WIDTH(WIDTH), .RSTV('0)) u_wd (
        .clk   (clk),
        .reset (reset),
        .en    (we_d),
        .d     (wd_d),
        .q     (wd_q)
    );

    assign o_wa = wa_q;
    assign o_wd = wd_q;

    // Sticky completion flag, set on the same edge the FSM enters RUN.
    base_vlat_en #(.WIDTH(1), .RSTV(1'b0)) u_done (
        .clk   (clk),
        .reset (reset),
        .en    (done_set),
        .d     (1'b1),
        .q     (o_done)
    );

`ifdef BASE_INITSINK_CHECK_EN
    logic [LOG_COUNT-1:0] exp_q;
    logic [LOG_COUNT-1:0] exp_d;
    logic                 exp_en;
    logic                 err_set;

    // Expected index counts down from the top entry; any beat after init is an error.
    always_comb begin
        exp_en  = init_acc & (state_q == ST_INIT);
        exp_d   = exp_q - LOG_COUNT'(1);
        err_set = init_acc & ((state_q == ST_RUN) | (i_init_d != exp_q));
    end

    base_vlat_en #(.WIDTH(LOG_COUNT), .RSTV(LOG_COUNT'(COUNT - 1))) u_exp (
        .clk   (clk),
        .reset (reset),
        .en    (exp_en),
        .d     (exp_d),
        .q     (exp_q)
    );

    base_vlat_en #(.WIDTH(1), .RSTV(1'b0)) u_err (
        .clk   (clk),
        .reset (reset),
        .en    (err_set),
        .d     (1'b1),
        .q     (o_err)
    );
`else
    assign o_err = 1'b0;
`endif

endmodule : base_initsink
